hazard_scoreboard: RTL and testbench

//  Parametrised hazard unit for the RV32 pipeline. Adds a per-register scoreboard
//  for multi-cycle (MC) units (mul/div, wait-state loads) on top of load-use

---
 rtl/hazard_scoreboard.sv | 175 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the RV32 pipeline with a per-register scoreboard for
// multi-cycle (MC) units.
//
// Purpose:
//   Detects four hazards on the instruction in ID and stalls IF/ID on any of them:
//   - RAW against outstanding MC results
//   - load-use against a load in EX
//   - WAW against outstanding MC results
//   - a structural hazard when the MC unit is full
//   A taken branch or jump flushes IF/ID and ID/EX, and takes priority over a stall.
//   The unit also keeps a saturating stall counter and a sticky stall watchdog.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_use_rs1/rs2    ID source registers and their read enables
//   id_rd, id_reg_write, id_mc       ID destination, write enable, MC-op flag
//   ex_rd, ex_mem_read, ex_reg_write EX destination, load flag, write enable
//   mc_done, mc_done_rd              MC writeback strobe and destination
//   branch_taken, jump_taken         EX control-flow redirect
//   stall_if/stall_id, flush_id/ex   pipeline control
//   pc_write_enable, if_id_write_enable  inverted stalls
//   sb_busy                          scoreboard (bit 0 always 0)
//   stall_count                      saturating count of stall cycles
//   hazard_timeout, sb_error         sticky watchdog / scoreboard-misuse flags
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned MC_DEPTH   = 2,
  parameter int unsigned PERF_W     = 16,
  parameter int unsigned WDOG_LIMIT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REG_ADDR_W-1:0]         id_rs1,
  input  logic [REG_ADDR_W-1:0]         id_rs2,
  input  logic                          id_use_rs1,
  input  logic                          id_use_rs2,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_reg_write,
  input  logic                          id_mc,
  input  logic [REG_ADDR_W-1:0]         ex_rd,
  input  logic                          ex_mem_read,
  input  logic                          ex_reg_write,
  input  logic                          mc_done,
  input  logic [REG_ADDR_W-1:0]         mc_done_rd,
  input  logic                          branch_taken,
  input  logic                          jump_taken,
  output logic                          stall_if,
  output logic                          stall_id,
  output logic                          flush_id,
  output logic                          flush_ex,
  output logic                          pc_write_enable,
  output logic                          if_id_write_enable,
  output logic [(1<<REG_ADDR_W)-1:0]    sb_busy,
  output logic [PERF_W-1:0]             stall_count,
  output logic                          hazard_timeout,
  output logic                          sb_error
);

  localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;
  localparam int unsigned CNT_MC_W = $clog2(MC_DEPTH + 1);
  localparam int unsigned WDOG_W   = $clog2(WDOG_LIMIT + 1);

  localparam logic [CNT_MC_W-1:0] McDepthCnt = CNT_MC_W'(MC_DEPTH);
  localparam logic [WDOG_W-1:0]   WdogMax    = WDOG_W'(WDOG_LIMIT);

  logic [NUM_REGS-1:0] sb_busy_q, sb_busy_d;
  logic [CNT_MC_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [PERF_W-1:0]   stall_count_q, stall_count_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                timeout_q, timeout_d;
  logic                sb_error_q, sb_error_d;

  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_eff;
  logic                raw_mc, load_use, waw, struct_hz, hz, redirect, issue;

  // A result written back this cycle is forwarded, so its register is not
  // treated as busy by the hazard checks.
  always_comb begin
    clr_vec = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      clr_vec[r] = mc_done && (mc_done_rd == REG_ADDR_W'(r));
    end
    busy_eff = sb_busy_q & ~clr_vec;
  end

  always_comb begin
    raw_mc    = (id_use_rs1 && (id_rs1 != '0) && busy_eff[id_rs1]) ||
                (id_use_rs2 && (id_rs2 != '0) && busy_eff[id_rs2]);
    load_use  = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    waw       = id_reg_write && (id_rd != '0) && busy_eff[id_rd];
    struct_hz = id_mc && (mc_cnt_q == McDepthCnt) && !mc_done;
    hz        = raw_mc || load_use || waw || struct_hz;
    redirect  = branch_taken || jump_taken;
    issue     = id_mc && id_reg_write && !hz && !redirect;
  end

  // Redirect wins over a stall: the stalled instruction is squashed anyway.
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (redirect) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (hz) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
    pc_write_enable    = !stall_if;
    if_id_write_enable = !stall_id;
  end

  always_comb begin
    sb_busy_d = sb_busy_q;
    // Clear first so that a same-cycle issue to the same register wins.
    if (mc_done) begin
      sb_busy_d[mc_done_rd] = 1'b0;
    end
    if (issue && (id_rd != '0)) begin
      sb_busy_d[id_rd] = 1'b1;
    end
    sb_busy_d[0] = 1'b0;

    // A completion with nothing outstanding is an error and does not decrement.
    mc_cnt_d = mc_cnt_q;
    if (issue) begin
      mc_cnt_d = mc_cnt_d + CNT_MC_W'(1);
    end
    if (mc_done && (mc_cnt_q != '0)) begin
      mc_cnt_d = mc_cnt_d - CNT_MC_W'(1);
    end

    sb_error_d = sb_error_q ||
                 (mc_done && (!sb_busy_q[mc_done_rd] || (mc_cnt_q == '0)));

    stall_count_d = stall_count_q;
    if (stall_id && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + PERF_W'(1);
    end

    wdog_d = '0;
    if (stall_id) begin
      wdog_d = (wdog_q == WdogMax) ? wdog_q : wdog_q + WDOG_W'(1);
    end
    timeout_d = timeout_q || (wdog_d == WdogMax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_busy_q     <= '0;
      mc_cnt_q      <= '0;
      stall_count_q <= '0;
      wdog_q        <= '0;
      timeout_q     <= 1'b0;
      sb_error_q    <= 1'b0;
    end else begin
      sb_busy_q     <= sb_busy_d;
      mc_cnt_q      <= mc_cnt_d;
      stall_count_q <= stall_count_d;
      wdog_q        <= wdog_d;
      timeout_q     <= timeout_d;
      sb_error_q    <= sb_error_d;
    end
  end

  assign sb_busy        = sb_busy_q;
  assign stall_count    = stall_count_q;
  assign hazard_timeout = timeout_q;
  assign sb_error       = sb_error_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  id_rs1, id_rs2, id_rd, ex_rd, mc_done_rd;
  logic        id_use_rs1, id_use_rs2, id_reg_write, id_mc;
  logic        ex_mem_read, ex_reg_write, mc_done, branch_taken, jump_taken;
  logic        stall_if, stall_id, flush_id, flush_ex;
  logic        pc_write_enable, if_id_write_enable;
  logic [15:0] sb_busy;
  logic [15:0] stall_count;
  logic        hazard_timeout, sb_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_ADDR_W(4),
    .MC_DEPTH  (2),
    .PERF_W    (16),
    .WDOG_LIMIT(4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_use_rs1        (id_use_rs1),
    .id_use_rs2        (id_use_rs2),
    .id_rd             (id_rd),
    .id_reg_write      (id_reg_write),
    .id_mc             (id_mc),
    .ex_rd             (ex_rd),
    .ex_mem_read       (ex_mem_read),
    .ex_reg_write      (ex_reg_write),
    .mc_done           (mc_done),
    .mc_done_rd        (mc_done_rd),
    .branch_taken      (branch_taken),
    .jump_taken        (jump_taken),
    .stall_if          (stall_if),
    .stall_id          (stall_id),
    .flush_id          (flush_id),
    .flush_ex          (flush_ex),
    .pc_write_enable   (pc_write_enable),
    .if_id_write_enable(if_id_write_enable),
    .sb_busy           (sb_busy),
    .stall_count       (stall_count),
    .hazard_timeout    (hazard_timeout),
    .sb_error          (sb_error)
  );

  task automatic clear_in();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_rd = '0; mc_done_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0; id_mc = 0;
    ex_mem_read = 0; ex_reg_write = 0; mc_done = 0;
    branch_taken = 0; jump_taken = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (sb_busy !== 16'h0000) begin
      bad++; $display("FAIL reset_sb_busy got=%h want=%h", sb_busy, 16'h0000);
    end
    total++;
    if (stall_count !== 16'd0) begin
      bad++; $display("FAIL reset_stall_count got=%0d want=0", stall_count);
    end
    total++;
    if ({hazard_timeout, sb_error} !== 2'b00) begin
      bad++; $display("FAIL reset_flags got=%b want=00", {hazard_timeout, sb_error});
    end
    total++;
    if ({stall_if, stall_id, flush_id, flush_ex, pc_write_enable, if_id_write_enable}
        !== 6'b000011) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000011",
               {stall_if, stall_id, flush_id, flush_ex, pc_write_enable, if_id_write_enable});
    end
  endtask

  task automatic test_raw_mc();
    do_reset();
    id_mc = 1; id_reg_write = 1; id_rd = 4'd5;
    #1;
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL raw_issue_nostall got=%b want=0", stall_id);
    end
    step();
    total++;
    if (sb_busy !== 16'h0020) begin
      bad++; $display("FAIL raw_busy_set got=%h want=0020", sb_busy);
    end
    clear_in();
    id_rs1 = 4'd5; id_use_rs1 = 1; id_rd = 4'd6; id_reg_write = 1;
    #1;
    total++;
    if ({stall_id, stall_if, flush_ex, flush_id} !== 4'b1110) begin
      bad++; $display("FAIL raw_stall got=%b want=1110", {stall_id, stall_if, flush_ex, flush_id});
    end
    step();
    total++;
    if ({stall_id, flush_ex} !== 2'b11) begin
      bad++; $display("FAIL raw_stall_held got=%b want=11", {stall_id, flush_ex});
    end
    step();
    mc_done = 1; mc_done_rd = 4'd5;
    #1;
    total++;
    if ({stall_id, flush_ex} !== 2'b00) begin
      bad++; $display("FAIL raw_bypass got=%b want=00", {stall_id, flush_ex});
    end
    step();
    clear_in();
    total++;
    if (sb_busy !== 16'h0000) begin
      bad++; $display("FAIL raw_busy_clr got=%h want=0000", sb_busy);
    end
    total++;
    if (stall_count !== 16'd2) begin
      bad++; $display("FAIL raw_stall_count got=%0d want=2", stall_count);
    end
    total++;
    if (sb_error !== 1'b0) begin
      bad++; $display("FAIL raw_no_error got=%b want=0", sb_error);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 4'd3;
    id_rs1 = 4'd3; id_use_rs1 = 1; id_rs2 = 4'd1; id_use_rs2 = 1;
    id_rd = 4'd4; id_reg_write = 1;
    #1;
    total++;
    if ({stall_id, pc_write_enable, if_id_write_enable, flush_ex} !== 4'b1001) begin
      bad++;
      $display("FAIL lu_stall got=%b want=1001",
               {stall_id, pc_write_enable, if_id_write_enable, flush_ex});
    end
    step();
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = '0;
    #1;
    total++;
    if ({stall_id, pc_write_enable} !== 2'b01) begin
      bad++; $display("FAIL lu_release got=%b want=01", {stall_id, pc_write_enable});
    end
    step();
    total++;
    if (stall_count !== 16'd1) begin
      bad++; $display("FAIL lu_count got=%0d want=1", stall_count);
    end
    // Load to x0 never creates a dependency.
    clear_in();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 4'd0; id_rs1 = 4'd0; id_use_rs1 = 1;
    #1;
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL lu_x0 got=%b want=0", stall_id);
    end
    clear_in();
  endtask

  task automatic test_struct();
    do_reset();
    id_mc = 1; id_reg_write = 1; id_rd = 4'd6;
    step();
    id_rd = 4'd7;
    step();
    id_rd = 4'd8;
    #1;
    total++;
    if (stall_id !== 1'b1) begin
      bad++; $display("FAIL struct_stall got=%b want=1", stall_id);
    end
    step();
    total++;
    if (sb_busy !== 16'h00C0) begin
      bad++; $display("FAIL struct_busy got=%h want=00c0", sb_busy);
    end
    mc_done = 1; mc_done_rd = 4'd6;
    #1;
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL struct_done_nostall got=%b want=0", stall_id);
    end
    step();
    mc_done = 0;
    total++;
    if (sb_busy !== 16'h0180) begin
      bad++; $display("FAIL struct_busy2 got=%h want=0180", sb_busy);
    end
    // Count must still be full: another MC op stalls.
    id_rd = 4'd9;
    #1;
    total++;
    if (stall_id !== 1'b1) begin
      bad++; $display("FAIL struct_still_full got=%b want=1", stall_id);
    end
    // WAW: plain write to a busy register stalls.
    id_mc = 0; id_rd = 4'd7;
    #1;
    total++;
    if (stall_id !== 1'b1) begin
      bad++; $display("FAIL waw_stall got=%b want=1", stall_id);
    end
    clear_in();
  endtask

  task automatic test_redirect();
    do_reset();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 4'd3;
    id_rs1 = 4'd3; id_use_rs1 = 1;
    id_mc = 1; id_reg_write = 1; id_rd = 4'd10; branch_taken = 1;
    #1;
    total++;
    if ({flush_id, flush_ex, stall_if, stall_id, pc_write_enable} !== 5'b11001) begin
      bad++;
      $display("FAIL br_over_stall got=%b want=11001",
               {flush_id, flush_ex, stall_if, stall_id, pc_write_enable});
    end
    step();
    total++;
    if (sb_busy !== 16'h0000) begin
      bad++; $display("FAIL br_no_issue got=%h want=0000", sb_busy);
    end
    clear_in();
    id_mc = 1; id_reg_write = 1; id_rd = 4'd10; jump_taken = 1;
    #1;
    total++;
    if ({flush_id, flush_ex, stall_id} !== 3'b110) begin
      bad++; $display("FAIL jmp_flush got=%b want=110", {flush_id, flush_ex, stall_id});
    end
    step();
    clear_in();
    total++;
    if ({sb_busy, stall_count} !== 32'h0) begin
      bad++; $display("FAIL jmp_state got=%h want=0", {sb_busy, stall_count});
    end
  endtask

  task automatic test_x0_error();
    do_reset();
    id_mc = 1; id_reg_write = 1; id_rd = 4'd0;
    #1;
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL x0_nostall got=%b want=0", stall_id);
    end
    step();
    clear_in();
    total++;
    if (sb_busy !== 16'h0000) begin
      bad++; $display("FAIL x0_busy got=%h want=0000", sb_busy);
    end
    mc_done = 1; mc_done_rd = 4'd9;
    step();
    clear_in();
    total++;
    if (sb_error !== 1'b1) begin
      bad++; $display("FAIL err_set got=%b want=1", sb_error);
    end
    step();
    total++;
    if (sb_error !== 1'b1) begin
      bad++; $display("FAIL err_sticky got=%b want=1", sb_error);
    end
    // Underflow from an empty MC unit also flags.
    do_reset();
    mc_done = 1; mc_done_rd = 4'd5;
    step();
    clear_in();
    total++;
    if (sb_error !== 1'b1) begin
      bad++; $display("FAIL err_underflow got=%b want=1", sb_error);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    id_mc = 1; id_reg_write = 1; id_rd = 4'd5;
    step();
    clear_in();
    id_rs2 = 4'd5; id_use_rs2 = 1;
    step();
    step();
    step();
    total++;
    if (hazard_timeout !== 1'b0) begin
      bad++; $display("FAIL wdog_early got=%b want=0", hazard_timeout);
    end
    step();
    total++;
    if (hazard_timeout !== 1'b1) begin
      bad++; $display("FAIL wdog_fire got=%b want=1", hazard_timeout);
    end
    total++;
    if (stall_count !== 16'd4) begin
      bad++; $display("FAIL wdog_count got=%0d want=4", stall_count);
    end
    // Asynchronous reset mid-stall, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({sb_busy, stall_count, hazard_timeout, sb_error, stall_id} !== 35'h0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0",
               {sb_busy, stall_count, hazard_timeout, sb_error, stall_id});
    end
    rst_n = 1'b1;
    clear_in();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    test_reset();
    test_raw_mc();
    test_load_use();
    test_struct();
    test_redirect();
    test_x0_error();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
